// File: rtl/mult_pkg.sv
// Shared constants, FSM state type and parity helper for the sequential multiplier responder.
package mult_pkg;
    localparam int unsigned ARG_W = 16;
    localparam int unsigned RES_W = 2 * ARG_W;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, CALC, DONE, WAIT_REL} state_t;

    // Even parity of a vector; narrower operands are zero-extended by the caller.
    function automatic logic even_parity(input logic [RES_W-1:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/mult_seq_responder_if.sv
// Operand request / result bus between the stimulus side and the multiplier responder.
interface mult_seq_responder_if;
    import mult_pkg::*;

    logic [ARG_W-1:0] arg_a;
    logic             arg_a_parity;
    logic [ARG_W-1:0] arg_b;
    logic             arg_b_parity;
    logic             req;
    logic             ack;
    logic [RES_W-1:0] result;
    logic             result_parity;
    logic             result_rdy;
    logic             arg_parity_error;

    modport master (
        output arg_a, arg_a_parity, arg_b, arg_b_parity, req,
        input  ack, result, result_parity, result_rdy, arg_parity_error
    );

    modport slave (
        input  arg_a, arg_a_parity, arg_b, arg_b_parity, req,
        output ack, result, result_parity, result_rdy, arg_parity_error
    );
endinterface

// File: rtl/mult_shift_add_core.sv
// Unsigned 16-iteration shift-add multiplier; done is high during the final iteration cycle.
module mult_shift_add_core
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ARG_W-1:0] mcand,
    input  logic [ARG_W-1:0] mplier,
    output logic [RES_W-1:0] prod,
    output logic             done
);
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] mc;
    logic [ARG_W-1:0] mp;

    // done is registered one iteration early so the controller leaves CALC on the last iteration edge
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            mc   <= '0;
            mp   <= '0;
            done <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            mc   <= RES_W'(mcand);
            mp   <= mplier;
            done <= 1'b0;
        end else if (busy) begin
            if (mp[0]) begin
                acc <= acc + mc;
            end
            mc   <= mc << 1;
            mp   <= mp >> 1;
            cnt  <= cnt + CNT_W'(1);
            done <= (cnt == CNT_W'(ARG_W - 2));
            if (cnt == CNT_W'(ARG_W - 1)) begin
                busy <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign prod = acc;
endmodule

// File: rtl/mult_seq_responder.sv
// Responder side of the multiplier req/ack protocol: parity check, sign handling and result registers.
module mult_seq_responder
    import mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mult_seq_responder_if.slave   bus
);
    state_t           state, state_n;
    logic             sign, sign_n;
    logic             err, err_n;
    logic             ack_q, ack_n;
    logic             rdy_q, rdy_n;
    logic [RES_W-1:0] res_q, res_n;
    logic             rpar_q, rpar_n;
    logic             perr_q, perr_n;
    logic             start_c;

    logic             a_err_c, b_err_c;
    logic [ARG_W-1:0] mag_a_c, mag_b_c;
    logic [RES_W-1:0] prod, prod_signed_c;
    logic             core_done;

    // Magnitudes as unsigned 16-bit values; -32768 maps cleanly to 0x8000
    assign a_err_c = even_parity(RES_W'(bus.arg_a)) != bus.arg_a_parity;
    assign b_err_c = even_parity(RES_W'(bus.arg_b)) != bus.arg_b_parity;
    assign mag_a_c = bus.arg_a[ARG_W-1] ? (~bus.arg_a + ARG_W'(1)) : bus.arg_a;
    assign mag_b_c = bus.arg_b[ARG_W-1] ? (~bus.arg_b + ARG_W'(1)) : bus.arg_b;
    assign prod_signed_c = sign ? (~prod + RES_W'(1)) : prod;

    mult_shift_add_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .mcand  (mag_a_c),
        .mplier (mag_b_c),
        .prod   (prod),
        .done   (core_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sign   <= 1'b0;
            err    <= 1'b0;
            ack_q  <= 1'b0;
            rdy_q  <= 1'b0;
            res_q  <= '0;
            rpar_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_n;
            sign   <= sign_n;
            err    <= err_n;
            ack_q  <= ack_n;
            rdy_q  <= rdy_n;
            res_q  <= res_n;
            rpar_q <= rpar_n;
            perr_q <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        sign_n  = sign;
        err_n   = err;
        ack_n   = 1'b0;
        rdy_n   = 1'b0;
        res_n   = res_q;
        rpar_n  = rpar_q;
        perr_n  = perr_q;
        start_c = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    ack_n  = 1'b1;
                    err_n  = a_err_c | b_err_c;
                    sign_n = bus.arg_a[ARG_W-1] ^ bus.arg_b[ARG_W-1];
                    if (a_err_c | b_err_c) begin
                        state_n = DONE;
                    end else begin
                        start_c = 1'b1;
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (core_done) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                rdy_n = 1'b1;
                if (err) begin
                    res_n  = '0;
                    rpar_n = 1'b0;
                    perr_n = 1'b1;
                end else begin
                    res_n  = prod_signed_c;
                    rpar_n = even_parity(prod_signed_c);
                    perr_n = 1'b0;
                end
                state_n = WAIT_REL;
            end
            WAIT_REL: begin
                if (!bus.req) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ack              = ack_q;
    assign bus.result_rdy       = rdy_q;
    assign bus.result           = res_q;
    assign bus.result_parity    = rpar_q;
    assign bus.arg_parity_error = perr_q;
endmodule

// File: tb/tb_mult_seq_responder.sv
// Scoreboard bench for mult_seq_responder: driver pushes expected results, monitor checks on result_rdy.
module tb_mult_seq_responder;
    logic clk;
    logic rst;

    mult_seq_responder_if bus();

    mult_seq_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        par;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor: compare every result_rdy pulse against the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.result_rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rdy actual=result_rdy with result=%h required=no pulse", bus.result);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("result_parity", 32'(bus.result_parity), 32'(e.par));
                    chk("arg_parity_error", 32'(bus.arg_parity_error), 32'(e.err));
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input logic p, input logic e);
        exp_t x;
        x.res = r;
        x.par = p;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
        chk({tag, "_result"}, bus.result, 32'd0);
        chk({tag, "_result_parity"}, 32'(bus.result_parity), 32'd0);
        chk({tag, "_result_rdy"}, 32'(bus.result_rdy), 32'd0);
        chk({tag, "_arg_parity_error"}, 32'(bus.arg_parity_error), 32'd0);
    endtask

    // One full transaction starting at a negedge; returns at a negedge with req low
    task automatic run_txn(input logic [15:0] a, input logic ap, input logic [15:0] b, input logic bp,
                           input logic [31:0] er, input logic ep, input logic ee, input int lat);
        int n;
        push_exp(er, ep, ee);
        bus.arg_a = a;
        bus.arg_a_parity = ap;
        bus.arg_b = b;
        bus.arg_b_parity = bp;
        bus.req = 1'b1;
        @(negedge clk);
        chk("ack_one_cycle_after_req", 32'(bus.ack), 32'd1);
        n = 0;
        while (bus.ack !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bus.req = 1'b0;
        n = 0;
        while (bus.result_rdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1 && bus.result_rdy !== 1'b1) chk("ack_width", 32'(bus.ack), 32'd0);
        end
        chk("rdy_latency", 32'(n), 32'(lat));
        @(negedge clk);
        chk("rdy_width", 32'(bus.result_rdy), 32'd0);
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = 32'($signed(a)) * 32'($signed(b));
        return p;
    endfunction

    initial begin
        logic [15:0] va[7];
        logic [15:0] vb[7];
        logic        bad_a[7];
        logic        bad_b[7];
        int acks, rdys;

        bus.arg_a = '0;
        bus.arg_a_parity = 1'b0;
        bus.arg_b = '0;
        bus.arg_b_parity = 1'b0;
        bus.req = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 3 * -5
        run_txn(16'd3, 1'b0, 16'hFFFB, 1'b1, 32'hFFFFFFF1, 1'b1, 1'b0, 17);

        // Reset 8 cycles into CALC: no result, outputs cleared
        bus.arg_a = 16'd100;
        bus.arg_a_parity = ^bus.arg_a;
        bus.arg_b = 16'd100;
        bus.arg_b_parity = ^bus.arg_b;
        bus.req = 1'b1;
        @(negedge clk);
        chk("abort_ack", 32'(bus.ack), 32'd1);
        bus.req = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_outputs_zero("abort");
        repeat (25) @(negedge clk);
        chk("abort_no_rdy", 32'(bus.result_rdy), 32'd0);

        // 7 * 6 = 42
        run_txn(16'd7, 1'b1, 16'd6, 1'b0, 32'h0000002A, 1'b1, 1'b0, 17);
        // -32768 * -32768
        run_txn(16'h8000, 1'b1, 16'h8000, 1'b1, 32'h40000000, 1'b1, 1'b0, 17);
        // Wrong parity on a
        run_txn(16'd3, 1'b1, 16'd1, 1'b1, 32'h0, 1'b0, 1'b1, 1);

        // req held high across result_rdy: one ack and one result only
        push_exp(32'h00000019, 1'b1, 1'b0);
        bus.arg_a = 16'd5;
        bus.arg_a_parity = 1'b0;
        bus.arg_b = 16'd5;
        bus.arg_b_parity = 1'b0;
        bus.req = 1'b1;
        acks = 0;
        rdys = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.ack === 1'b1) acks++;
            if (bus.result_rdy === 1'b1) rdys++;
        end
        chk("hold_ack_count", 32'(acks), 32'd1);
        chk("hold_rdy_count", 32'(rdys), 32'd1);
        bus.req = 1'b0;
        @(negedge clk);
        run_txn(16'd0, 1'b0, 16'd12345, 1'b0, 32'h0, 1'b0, 1'b0, 17);

        // Back-to-back mixed valid/invalid pairs against the reference product
        va = '{16'd123, 16'hFFFF, 16'h7FFF, 16'h1234, 16'hFF9C, 16'd255, 16'h8000};
        vb = '{16'hFE38, 16'hFFFF, 16'h8000, 16'h00FF, 16'd0, 16'd255, 16'd1};
        bad_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bad_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            logic        e;
            logic [31:0] r;
            e = bad_a[i] | bad_b[i];
            r = e ? 32'h0 : model(va[i], vb[i]);
            run_txn(va[i], (^va[i]) ^ bad_a[i], vb[i], (^vb[i]) ^ bad_b[i],
                    r, ^r, e, e ? 1 : 17);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
